// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Shares the single RegFile write port between the in-order pipeline
// writeback stage (always wins) and a one-entry hold buffer fed by the
// long-latency MDU. Tracks outstanding MDU destinations in a busy
// scoreboard and stalls decode on hazards against them. Also stalls decode
// when a buffered MDU result has waited too long, so that a bubble reaches WB.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,
    input  logic        dec_valid_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    output logic        stall_o,
    output logic        rf_wen_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
    output logic [31:0] busy_o
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    // Saturating increment for the starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic              buf_valid;
    logic [4:0]        buf_rd;
    logic [31:0]       buf_data;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       busy;
    logic [31:0]       busy_nxt;

    logic pipe_act;
    logic drain;
    logic mdu_xfer;
    logic buf_load;
    logic issue_set;
    logic haz;
    logic starve;

    assign pipe_act    = pipe_wen_i & (pipe_rd_i != 5'd0);
    assign drain       = buf_valid & ~pipe_act;
    // Ready depends only on registered state and reset, never on mdu inputs.
    assign mdu_ready_o = ~buf_valid & ~rst;
    assign mdu_xfer    = mdu_valid_i & mdu_ready_o;
    // Results aimed at x0 are consumed but never occupy the buffer.
    assign buf_load    = mdu_xfer & (mdu_rd_i != 5'd0);

    assign haz     = dec_valid_i & (busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i]);
    assign starve  = buf_valid & (wait_cnt >= CNT_LIMIT);
    assign stall_o = haz | starve;

    // Issues presented while decode is stalled do not really issue.
    assign issue_set = issue_valid_i & ~stall_o & (issue_rd_i != 5'd0);
    assign busy_o    = busy;

    // Write-port mux: pipeline first, then the buffered MDU result.
    always_comb begin
        rf_wen_o  = 1'b0;
        rf_rd_o   = 5'd0;
        rf_data_o = 32'd0;
        if (pipe_act) begin
            rf_wen_o  = 1'b1;
            rf_rd_o   = pipe_rd_i;
            rf_data_o = pipe_data_i;
        end else if (buf_valid) begin
            rf_wen_o  = 1'b1;
            rf_rd_o   = buf_rd;
            rf_data_o = buf_data;
        end
    end

    // Scoreboard update: clear on drain, then set on issue so a same-register set wins.
    always_comb begin
        busy_nxt = busy;
        if (drain) begin
            busy_nxt[buf_rd] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Hold-buffer occupancy; load and drain never coincide since load needs an empty buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
        end
    end

    // Hold-buffer payload; only meaningful while buf_valid is set.
    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_rd   <= mdu_rd_i;
            buf_data <= mdu_data_i;
        end
    end

    // Counts cycles the buffered result loses the port to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (drain) begin
            wait_cnt <= '0;
        end else if (buf_valid & pipe_act) begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, starvation
// sequences, then randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        pipe_wen_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        dec_valid_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  dec_rd_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        stall_o;
    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic [31:0] busy_o;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wen_i   (pipe_wen_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_rd_i     (mdu_rd_i),
        .mdu_data_i   (mdu_data_i),
        .mdu_ready_o  (mdu_ready_o),
        .dec_valid_i  (dec_valid_i),
        .dec_rs1_i    (dec_rs1_i),
        .dec_rs2_i    (dec_rs2_i),
        .dec_rd_i     (dec_rd_i),
        .issue_valid_i(issue_valid_i),
        .issue_rd_i   (issue_rd_i),
        .stall_o      (stall_o),
        .rf_wen_o     (rf_wen_o),
        .rf_rd_o      (rf_rd_o),
        .rf_data_o    (rf_data_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        dv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  drd;
        logic        iv;
        logic [4:0]  ird;
        logic        e_ready;
        logic        e_stall;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    // reference model state
    ent_t mq[$];
    bit   mbusy[32];
    int   mwait;

    function automatic vec_t mk(int r, int pw, int prd, int pdata, int mv, int mrd, int mdata,
                                int dv, int rs1, int rs2, int drd, int iv, int ird,
                                int rdy, int st, int wen, int erd, int edata, int ebusy);
        vec_t v;
        v.rst = 1'(r);   v.pw = 1'(pw);   v.prd = 5'(prd);   v.pdata = 32'(pdata);
        v.mv = 1'(mv);   v.mrd = 5'(mrd); v.mdata = 32'(mdata);
        v.dv = 1'(dv);   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);   v.drd = 5'(drd);
        v.iv = 1'(iv);   v.ird = 5'(ird);
        v.e_ready = 1'(rdy); v.e_stall = 1'(st); v.e_wen = 1'(wen);
        v.e_rd = 5'(erd); v.e_data = 32'(edata); v.e_busy = 32'(ebusy);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge, then wait to sample.
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst           = v.rst;
        pipe_wen_i    = v.pw;
        pipe_rd_i     = v.prd;
        pipe_data_i   = v.pdata;
        mdu_valid_i   = v.mv;
        mdu_rd_i      = v.mrd;
        mdu_data_i    = v.mdata;
        dec_valid_i   = v.dv;
        dec_rs1_i     = v.rs1;
        dec_rs2_i     = v.rs2;
        dec_rd_i      = v.drd;
        issue_valid_i = v.iv;
        issue_rd_i    = v.ird;
        #3;
    endtask

    task automatic check_row(input string tag, input vec_t v);
        chk($sformatf("%s mdu_ready", tag), 32'(mdu_ready_o), 32'(v.e_ready));
        chk($sformatf("%s stall", tag),     32'(stall_o),     32'(v.e_stall));
        chk($sformatf("%s rf_wen", tag),    32'(rf_wen_o),    32'(v.e_wen));
        chk($sformatf("%s rf_rd", tag),     32'(rf_rd_o),     32'(v.e_rd));
        chk($sformatf("%s rf_data", tag),   rf_data_o,        v.e_data);
        chk($sformatf("%s busy", tag),      busy_o,           v.e_busy);
    endtask

    // Expected outputs from the model's current state and the applied inputs.
    task automatic model_expect(input vec_t v, output vec_t e);
        bit pipe_on;
        bit haz;
        e = v;
        pipe_on   = v.pw && (v.prd != 0);
        e.e_ready = !v.rst && (mq.size() == 0);
        haz       = v.dv && (mbusy[v.rs1] || mbusy[v.rs2] || mbusy[v.drd]);
        e.e_stall = haz || (mq.size() > 0 && mwait >= LIMIT);
        e.e_wen = 1'b0; e.e_rd = 5'd0; e.e_data = 32'd0;
        if (pipe_on) begin
            e.e_wen = 1'b1; e.e_rd = v.prd; e.e_data = v.pdata;
        end else if (mq.size() > 0) begin
            e.e_wen = 1'b1; e.e_rd = mq[0].rd; e.e_data = mq[0].data;
        end
        e.e_busy = 32'd0;
        for (int i = 1; i < 32; i++) e.e_busy[i] = mbusy[i];
    endtask

    // Advance the model across one clock edge.
    task automatic model_commit(input vec_t e);
        bit   pipe_on;
        ent_t ent;
        pipe_on = e.pw && (e.prd != 0);
        if (e.rst) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            mwait = 0;
        end else begin
            if (!pipe_on && mq.size() > 0) begin
                mbusy[mq[0].rd] = 0;
                void'(mq.pop_front());
                mwait = 0;
            end else if (mq.size() > 0) begin
                mwait++;
            end
            if (e.mv && e.e_ready && e.mrd != 0) begin
                ent.rd = e.mrd; ent.data = e.mdata;
                mq.push_back(ent);
            end
            if (e.iv && !e.e_stall && e.ird != 0) mbusy[e.ird] = 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;

        // Directed table: each row is one cycle, expectations sampled before the edge.
        //           rst pw prd pdata  mv mrd mdata    dv rs1 rs2 drd iv ird  rdy st wen erd edata   busy
        tbl.push_back(mk(1, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 5, 'h1234,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 1, 5,  'h1234,  0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 7, 'h77,    0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 1, 3, 'hA,   0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 1, 3,  'hA,     0));
        tbl.push_back(mk(0, 1, 3, 'hB,   0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 1, 3,  'hB,     0));
        tbl.push_back(mk(0, 1, 0, 'hC,   0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 1, 7,  'h77,    0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  1, 9,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     1, 9, 'h99,    1, 1, 9, 2,  0, 0,   1, 1, 0, 0,  0,       'h200));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       1, 1, 9, 2,  0, 0,   0, 1, 1, 9,  'h99,    'h200));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       1, 1, 9, 2,  0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  1, 4,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       1, 0, 5, 0,  1, 0,   1, 0, 0, 0,  0,       'h10));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       1, 4, 0, 0,  1, 6,   1, 1, 0, 0,  0,       'h10));
        tbl.push_back(mk(0, 0, 0, 0,     1, 12, 'h1200, 0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       'h10));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  1, 12,  0, 0, 1, 12, 'h1200,  'h10));
        tbl.push_back(mk(0, 0, 0, 0,     1, 9, 'h5,     0, 0, 0, 0,  1, 9,   1, 0, 0, 0,  0,       'h1010));
        tbl.push_back(mk(0, 1, 1, 'h11,  1, 3, 'h33,    0, 0, 0, 0,  0, 0,   0, 0, 1, 1,  'h11,    'h1210));
        tbl.push_back(mk(1, 1, 2, 'h22,  0, 0, 0,       0, 0, 0, 0,  0, 0,   0, 0, 1, 2,  'h22,    'h1210));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       1, 4, 9, 12, 0, 0,   1, 0, 0, 0,  0,       0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0,  0, 0,   1, 0, 0, 0,  0,       0));

        // Power-on reset without checks: registers start unknown.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        drive(v);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            check_row($sformatf("vec%0d", i), tbl[i]);
        end

        // Starvation: buffer held behind continuous pipe writes.
        drive(mk(0, 0, 0, 0, 1, 20, 'h2020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("starve1 load ready", 32'(mdu_ready_o), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            v = mk(0, 1, 1, k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k >= 5) ? 1 : 0, 1, 1, k, 0);
            drive(v);
            check_row($sformatf("starve1 c%0d", k), v);
        end
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 20, 'h2020, 0);
        drive(v);
        check_row("starve1 drain", v);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(v);
        check_row("starve1 after", v);

        // Second load: the counter must have restarted from zero.
        drive(mk(0, 0, 0, 0, 1, 21, 'h2121, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("starve2 load ready", 32'(mdu_ready_o), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            v = mk(0, 1, 2, k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k >= 5) ? 1 : 0, 1, 2, k, 0);
            drive(v);
            check_row($sformatf("starve2 c%0d", k), v);
        end
        v = mk(0, 1, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 21, 'h2121, 0);
        drive(v);
        check_row("starve2 drain", v);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(v);
        check_row("starve2 after", v);

        // Randomized traffic against the reference model, starting from reset.
        mq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        mwait = 0;
        for (int c = 0; c < 3000; c++) begin
            v.rst   = (c == 0) || ($urandom_range(0, 63) == 0);
            v.pw    = 1'($urandom_range(0, 1));
            v.prd   = 5'($urandom_range(0, 7));
            v.pdata = $urandom;
            v.mv    = 1'($urandom_range(0, 1));
            v.mrd   = 5'($urandom_range(0, 7));
            v.mdata = $urandom;
            v.dv    = 1'($urandom_range(0, 1));
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            v.drd   = 5'($urandom_range(0, 7));
            v.iv    = ($urandom_range(0, 9) < 3);
            v.ird   = 5'($urandom_range(0, 7));
            drive(v);
            model_expect(v, e);
            check_row($sformatf("rand%0d", c), e);
            model_commit(e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Owns the single write port of the register file. Shares it between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU). Keeps a 32-entry busy scoreboard of registers that have MDU results outstanding, and stalls decode on RAW/WAW hazards against them. Sits between WB, MDU and decode, and drives the RegFile `wen_c`/`rd_i`/`rd_data_i` inputs directly.

## Interface
- `STARVE_LIMIT`, default 4: cycles a buffered MDU result may wait before decode is forced to stall so that a bubble drains to WB.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pipe_wen_i` in 1: pipeline WB write request. Always granted.
- `pipe_rd_i` in 5: pipeline WB destination register.
- `pipe_data_i` in 32: pipeline WB write data.
- `mdu_valid_i` in 1: MDU result valid.
- `mdu_rd_i` in 5: MDU result destination register.
- `mdu_data_i` in 32: MDU result data.
- `mdu_ready_o` out 1: arbiter can accept an MDU result.
- `dec_valid_i` in 1: decode holds a valid instruction.
- `dec_rs1_i` in 5: decode source register 1.
- `dec_rs2_i` in 5: decode source register 2.
- `dec_rd_i` in 5: decode destination register.
- `issue_valid_i` in 1: decode issues an MDU op this cycle.
- `issue_rd_i` in 5: destination register of the issued MDU op.
- `stall_o` out 1: stall decode.
- `rf_wen_o` out 1: RegFile write enable.
- `rf_rd_o` out 5: RegFile write address.
- `rf_data_o` out 32: RegFile write data.
- `busy_o` out 32: scoreboard, for debug and assertions. Bit 0 is always 0.

## Operation
- **Pipe-active:** `pipe_act = pipe_wen_i & (pipe_rd_i != 0)`. A pipeline write to x0 does not occupy the port.
- **MDU handshake:** valid/ready. A transfer occurs when `mdu_valid_i & mdu_ready_o`. `mdu_ready_o = !buf_valid & !rst`. There is no combinational path from the mdu inputs to `mdu_ready_o`.
- **Hold buffer:** a one-entry buffer (`buf_valid`, `buf_rd`, `buf_data`). A transfer loads the buffer. A transfer with `mdu_rd_i == 0` is accepted and discarded: the buffer is not loaded.
- **Port mux, priority pipe:**
  - If `pipe_act`, the rf outputs carry the pipe request.
  - Else if `buf_valid`, the rf outputs carry the buffer and the buffer drains (`buf_valid` clears at the edge).
  - Else `rf_wen_o = 0`.
  - With `rf_wen_o = 0`, `rf_rd_o` and `rf_data_o` are 0.
- **Scoreboard set:** at the edge, set `busy[issue_rd_i]` when `issue_valid_i & !stall_o & issue_rd_i != 0`. Issues made while `stall_o = 1` are ignored.
- **Scoreboard clear:** at the edge, clear `busy[buf_rd]` in the cycle the buffer drains. If a set and a clear hit the same register in the same cycle, the set wins.
- **Hazard stall:** `haz = dec_valid_i & (busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i])`.
  - busy[0] is 0, so x0 never stalls.
  - There is no bypass of a same-cycle clear: the stall releases the cycle after the drain.
- **Starvation counter:** `wait_cnt` is saturating, with width clog2(STARVE_LIMIT+1).
  - It increments each cycle `buf_valid & pipe_act`.
  - It clears to 0 on drain.
  - `starve = buf_valid & (wait_cnt >= STARVE_LIMIT)`.
- **Stall output:** `stall_o = haz | starve`. It is combinational.

## Timing
- **Reset values:** `busy_o = 0`, `buf_valid = 0`, `wait_cnt = 0`, `stall_o = 0` (with `dec_valid_i = 0`), `rf_wen_o = 0`, `mdu_ready_o = 0` while `rst` is high and 1 the cycle after.
- **Reset mid-operation:** any buffered result is dropped and every busy bit is cleared. Recovery from this is the MDU's and pipeline's job, since reset also flushes them.
- **MDU write latency:** accepted at edge N, RegFile written at edge N+1 at the earliest, when `pipe_act = 0` in cycle N+1.
- **Throughput:** the MDU may present back-to-back results. Maximum throughput is one result every 2 cycles, because `mdu_ready_o` drops while the buffer is full.
- **Pipeline writes:** zero added latency. The rf outputs are a combinational function of the pipe inputs and the buffer state.
- **Busy bit timing:**
  - Visible the cycle after issue.
  - The consumer stall releases the cycle after the drain edge, so the RegFile read sees the new value.
- **Starvation bound:** with continuous `pipe_act`, `stall_o` rises in cycle STARVE_LIMIT+1 after the buffer load. It stays high until the drain.

## Test plan
- **Idle drain:** reset, then MDU transfer rd=5 data=0x1234 with pipe idle → `mdu_ready_o` 0 for one cycle. The next cycle has `rf_wen_o=1`, `rf_rd_o=5`, `rf_data_o=0x1234`. `mdu_ready_o` is back to 1 after the drain.
- **Collision:** buffered rd=7 while pipe writes rd=3 for 2 cycles → the pipe owns the port for those 2 cycles. The rd=7 write lands in the first idle cycle. A pipe write to x0 counts as idle.
- **RAW stall:** issue rd=9, then decode rs2=9 → `stall_o=1` until the cycle after the rd=9 drain. Also check rs1=0 and rd=0 never stall, and that an issue with rd=0 sets no busy bit.
- **Starvation:** STARVE_LIMIT=4, buffer loaded, `pipe_act` held continuously → `stall_o=1` from cycle 5 with `dec_valid_i=0`. Then drop `pipe_act` → drain, `wait_cnt=0`, and `stall_o` deasserts next cycle.
- **Simultaneous set and clear:** issue rd=12 in the same cycle a buffered rd=12 drains (issue while busy is blocked, so bench forces `dec_valid_i=0`) → `busy[12]` remains 1.
- **Reset mid-operation:** `rst` asserted with buffer full and busy bits {4, 9} set → next cycle `busy_o=0`, no rf write, and `mdu_ready_o=1` once `rst` is low.
